ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter: INST_NOP, default 32'h00000013, the reset and flush value of inst.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: pc  input  32  current PC from the write-back unit; changes only on the edge where pc_update_en=1.
REQ-005 SHALL have port: pc_update_en  input  1  the current instruction retires; pc takes the next-PC value at this edge.
REQ-006 SHALL have port: araddr  output  32  instruction-read address.
REQ-007 SHALL have port: arvalid  output  1  read request valid.
REQ-008 SHALL have port: arready  input  1  memory accepts the request.
REQ-009 SHALL have port: rdata  input  32  read data.
REQ-010 SHALL have port: rresp  input  2  read response; 0 means OK, nonzero means error.
REQ-011 SHALL have port: rvalid  input  1  read data valid.
REQ-012 SHALL have port: rready  output  1  fetch unit accepts the read data.
REQ-013 SHALL have port: inst  output  32  fetched instruction, registered.
REQ-014 SHALL have port: inst_valid  output  1  inst is valid for the current pc.
REQ-015 SHALL have port: fetch_err  output  1  sticky fetch-fault flag.

Function
REQ-016 SHALL use a state machine with states IDLE, AR, R, HOLD and ERR.
REQ-017 SHALL go from IDLE to AR on the first clock after reset is released, unconditionally.
REQ-018 In AR, SHALL assert arvalid=1 with araddr=pc, and SHALL go to R on the edge where arvalid and arready are both 1.
REQ-019 In AR, SHALL hold arvalid at 1 and araddr stable until arready=1; there is no timeout.
REQ-020 In R, SHALL assert rready=1.
REQ-021 In R, on the edge where rvalid=1 and rresp=0, SHALL latch rdata into inst, set inst_valid=1 and go to HOLD.
REQ-022 In R, on the edge where rvalid=1 and rresp!=0, SHALL keep inst_valid=0, set fetch_err=1 and go to ERR.
REQ-023 Outside R, SHALL drive rready=0; outside AR, SHALL drive arvalid=0.
REQ-024 In HOLD, SHALL keep inst and inst_valid stable until pc_update_en=1.
REQ-025 In HOLD, on the edge where pc_update_en=1, SHALL clear inst_valid to 0 and go directly to AR, so the next request uses the updated pc.
REQ-026 SHALL ignore pc_update_en in every state except HOLD.
REQ-027 ERR SHALL be terminal: arvalid=0, rready=0, inst_valid=0, fetch_err=1 until reset.
REQ-028 SHALL allow arready and rvalid to arrive in the same cycle the request is issued; minimum fetch latency is 2 cycles from entering AR to inst_valid=1.
REQ-029 SHALL have at most one outstanding read; rvalid outside R SHALL be ignored.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force: state=IDLE, arvalid=0, rready=0, inst=INST_NOP, inst_valid=0, fetch_err=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding read; a stale rvalid after release SHALL be ignored (state is not R).

Configuration
REQ-032 Macro IFU_ALIGN_CHECK_EN, when defined, SHALL check pc[1:0] on entry to AR.
REQ-033 With IFU_ALIGN_CHECK_EN defined and pc[1:0]!=0, SHALL go to ERR with fetch_err=1 and SHALL NOT assert arvalid.
REQ-034 Without IFU_ALIGN_CHECK_EN, SHALL issue the request for any pc unchanged, with no alignment logic.

Verification
REQ-035 Bench SHALL cover: reset release with pc=32'h80000000, arready=1, rvalid=1 the next cycle, rdata=32'h00100093 -> arvalid in cycle 1, inst=32'h00100093 and inst_valid=1 in cycle 3.
REQ-036 Bench SHALL cover: arready held 0 for 5 cycles -> arvalid=1 and araddr=32'h80000000 stable all 5 cycles, no state advance.
REQ-037 Bench SHALL cover: in HOLD, pc_update_en pulse while pc changes to 32'h80000004 -> inst_valid=0 the next cycle, araddr=32'h80000004.
REQ-038 Bench SHALL cover: rvalid=1 with rresp=2'b10 -> fetch_err=1, inst_valid=0, no further arvalid until reset.
REQ-039 Bench SHALL cover: rst_n dropped while in R, then rvalid=1 after release -> inst=INST_NOP, inst_valid=0, a fresh request is issued.
REQ-040 Bench SHALL cover: with IFU_ALIGN_CHECK_EN and pc=32'h80000002 -> fetch_err=1 and arvalid never 1; without the macro -> araddr=32'h80000002 is issued.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit with an AXI-lite style read channel.
// The fetch loop is IDLE -> AR -> R -> HOLD -> AR ... and ERR is terminal until reset.
// Optional build macro IFU_ALIGN_CHECK_EN: when defined, a PC with nonzero pc[1:0] in AR
// suppresses the request and sends the unit to ERR.
module ifu_fetch #(
  parameter logic [31:0] INST_NOP = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        pc_update_en,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic        addr_ok_s;

  // The PC is only read in AR; it is stable there because it only moves on the
  // HOLD -> AR edge, so the alignment check and araddr can use it directly.
`ifdef IFU_ALIGN_CHECK_EN
  assign addr_ok_s = (pc[1:0] == 2'b00);
`else
  assign addr_ok_s = 1'b1;
`endif

  // Next-state and datapath decision for the fetch loop.
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    fetch_err_d  = fetch_err_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_AR;
      end
      S_AR: begin
        if (!addr_ok_s) begin
          state_d     = S_ERR;
          fetch_err_d = 1'b1;
        end else if (arready) begin
          state_d = S_R;
        end else begin
          state_d = S_AR;
        end
      end
      S_R: begin
        if (rvalid) begin
          if (rresp == 2'b00) begin
            inst_d       = rdata;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            inst_valid_d = 1'b0;
            fetch_err_d  = 1'b1;
            state_d      = S_ERR;
          end
        end else begin
          state_d = S_R;
        end
      end
      S_HOLD: begin
        if (pc_update_en) begin
          inst_valid_d = 1'b0;
          state_d      = S_AR;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_ERR: begin
        inst_valid_d = 1'b0;
        fetch_err_d  = 1'b1;
        state_d      = S_ERR;
      end
      default: begin
        inst_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  // State and instruction registers; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      inst_q       <= INST_NOP;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  assign araddr     = pc;
  assign arvalid    = (state_q == S_AR) && addr_ok_s;
  assign rready     = (state_q == S_R);
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = fetch_err_q;

endmodule
